// File: rtl/spi_target_wb.sv
// spi_target_wb: Wishbone-attached SPI target, mode 0, MSB first, 8-bit words.
// MOSI bytes land in an RX FIFO; MISO bytes come from a TX FIFO. The SPI pins
// are oversampled by clk_i through synchronizer chains; all logic is on clk_i.
module spi_target_wb #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        IRQ,
    input  logic        sclk,
    input  logic        csb,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Synchronizers; sclk/csb carry one extra flop for edge detection.
    logic [SYNC_STAGES:0]   sclk_pipe_q, sclk_pipe_d, csb_pipe_q, csb_pipe_d;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;

    logic        ack_q, ack_d, irq_q, irq_d, miso_q, miso_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  ctrl_q, ctrl_d;     // {end_ie, rx_ie, enable}
    logic [2:0]  sticky_q, sticky_d; // {frame_end, tx_unf, rx_ovf}
    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;

    logic [FIFO_DEPTH-1:0][7:0] rx_mem_q, rx_mem_d, tx_mem_q, tx_mem_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

    logic sclk_s, sclk_p, csb_s, csb_p, mosi_s;
    logic sclk_rise, sclk_fall, csb_rise, csb_fall, en;
    logic wb_req, rx_pop, tx_push, tx_accept, rx_push, rx_push_req;
    logic tx_load, tx_pop, set_end, set_unf, set_ovf;
    logic [2:0] w1c;
    logic [7:0] status, rx_byte;
    logic unused;

    assign unused = ^{sel_i, adr_i[31:4], adr_i[1:0], dat_i[31:8]};

    assign sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], sclk};
    assign csb_pipe_d  = {csb_pipe_q[SYNC_STAGES-1:0], csb};
    assign mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-2:0], mosi};

    assign sclk_s    = sclk_pipe_q[SYNC_STAGES-1];
    assign sclk_p    = sclk_pipe_q[SYNC_STAGES];
    assign csb_s     = csb_pipe_q[SYNC_STAGES-1];
    assign csb_p     = csb_pipe_q[SYNC_STAGES];
    assign mosi_s    = mosi_pipe_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_p;
    assign sclk_fall = ~sclk_s & sclk_p;
    assign csb_rise  = csb_s & ~csb_p;
    assign csb_fall  = ~csb_s & csb_p;
    assign en        = ctrl_q[0];
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};

    assign ack_o   = ack_q;
    assign dat_o   = dat_q;
    assign IRQ     = irq_q;
    assign miso_oe = en & ~csb_s;
    assign miso    = miso_oe & miso_q;

    // Wishbone register decode: one ack per strobe, side effects on the ack cycle.
    always_comb begin
        wb_req  = cyc_i & stb_i & ~ack_q;
        ack_d   = wb_req;
        dat_d   = '0;
        ctrl_d  = ctrl_q;
        rx_pop  = 1'b0;
        tx_push = 1'b0;
        w1c     = '0;
        status  = {sticky_q, en & ~csb_s, tx_cnt_q == FULL, tx_cnt_q == '0,
                   rx_cnt_q == FULL, rx_cnt_q == '0};
        if (wb_req) begin
            if (we_i) begin
                case (adr_i[3:2])
                    2'd1:    tx_push = 1'b1;
                    2'd2:    w1c = dat_i[7:5];
                    2'd3:    ctrl_d = dat_i[2:0];
                    default: ;
                endcase
            end else begin
                case (adr_i[3:2])
                    2'd0: if (rx_cnt_q != '0) begin
                        dat_d  = {24'd0, rx_mem_q[rx_rptr_q]};
                        rx_pop = 1'b1;
                    end
                    2'd2:    dat_d = {24'd0, status};
                    2'd3:    dat_d = {29'd0, ctrl_q};
                    default: ;
                endcase
            end
        end
    end

    // SPI engine: frame tracking, bit counting and the two shifters.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        pend_d      = pend_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_load     = 1'b0;
        tx_pop      = 1'b0;
        rx_push_req = 1'b0;
        set_end     = 1'b0;
        set_unf     = 1'b0;
        case (state_q)
            IDLE: if (csb_fall && en) begin
                state_d  = SHIFT;
                bitcnt_d = '0;
                pend_d   = 1'b0;
                tx_load  = 1'b1;
            end
            SHIFT: if (csb_rise || !en) begin
                // Partial bytes are simply dropped with the counter.
                state_d  = IDLE;
                bitcnt_d = '0;
                pend_d   = 1'b0;
                set_end  = csb_rise;
            end else if (sclk_rise) begin
                rx_shift_d = rx_byte;
                bitcnt_d   = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    rx_push_req = 1'b1;
                    pend_d      = 1'b1;
                end
            end else if (sclk_fall) begin
                if (pend_q) begin
                    tx_load = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        endcase
        if (tx_load) begin
            if (tx_cnt_q != '0) begin
                tx_shift_d = tx_mem_q[tx_rptr_q];
                tx_pop     = 1'b1;
            end else begin
                tx_shift_d = 8'h00;
                set_unf    = 1'b1;
            end
        end
        miso_d = (state_q == SHIFT) ? tx_shift_q[7] : 1'b0;
    end

    // FIFO bookkeeping, sticky flags and interrupt level.
    always_comb begin
        rx_push = 1'b0;
        set_ovf = 1'b0;
        if (rx_push_req) begin
            // A pop in the same cycle frees the slot for the push.
            if (rx_cnt_q != FULL || rx_pop) rx_push = 1'b1;
            else                            set_ovf = 1'b1;
        end
        tx_accept = tx_push && (tx_cnt_q != FULL || tx_pop);

        rx_mem_d = rx_mem_q;
        if (rx_push) rx_mem_d[rx_wptr_q] = rx_byte;
        rx_wptr_d = rx_wptr_q + PW'(rx_push);
        rx_rptr_d = rx_rptr_q + PW'(rx_pop);
        rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        tx_mem_d = tx_mem_q;
        if (tx_accept) tx_mem_d[tx_wptr_q] = dat_i[7:0];
        tx_wptr_d = tx_wptr_q + PW'(tx_accept);
        tx_rptr_d = tx_rptr_q + PW'(tx_pop);
        tx_cnt_d  = tx_cnt_q + CW'(tx_accept) - CW'(tx_pop);

        // Set events win over a same-cycle clear.
        sticky_d = (sticky_q & ~w1c) | {set_end, set_unf, set_ovf};
        irq_d    = (ctrl_q[1] & (rx_cnt_q != '0)) | (ctrl_q[2] & sticky_q[2]);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_pipe_q <= '0;
            csb_pipe_q  <= '1;
            mosi_pipe_q <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            miso_q      <= 1'b0;
            ctrl_q      <= '0;
            sticky_q    <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            pend_q      <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_mem_q    <= '0;
            tx_mem_q    <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
        end else begin
            sclk_pipe_q <= sclk_pipe_d;
            csb_pipe_q  <= csb_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            miso_q      <= miso_d;
            ctrl_q      <= ctrl_d;
            sticky_q    <= sticky_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            pend_q      <= pend_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_mem_q    <= rx_mem_d;
            tx_mem_q    <= tx_mem_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end
endmodule

// File: doc/spi_target_wb.md
# spi_target_wb

Wishbone-attached SPI target (slave) that responds to an external SPI controller, such as one of the CF_SPI_WB controllers in the user project. It receives MOSI bytes into an RX FIFO and shifts TX FIFO bytes out on MISO, in SPI mode 0, MSB first, 8-bit words. Software services it through four Wishbone registers and one level interrupt. It occupies one Wishbone peripheral slot and decodes only `adr_i[3:2]`.

## Interface
- `FIFO_DEPTH`, default 4: RX and TX FIFO depth in bytes; must be a power of 2 and at least 2.
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `csb` and `mosi`; must be at least 2.
- `clk_i` input 1: the single clock; all logic is on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `adr_i` input 32: Wishbone address; only bits [3:2] are decoded.
- `dat_i` input 32: Wishbone write data.
- `dat_o` output 32: Wishbone read data, registered.
- `sel_i` input 4: byte selects; ignored, every access is full-word.
- `cyc_i`, `stb_i`, `we_i` input 1 each: Wishbone cycle, strobe and write enable.
- `ack_o` output 1: Wishbone acknowledge.
- `IRQ` output 1: level interrupt.
- `sclk`, `csb`, `mosi` input 1 each: SPI pins driven by the external controller; asynchronous to `clk_i`.
- `miso` output 1: target data out.
- `miso_oe` output 1: output enable for the `miso` pad.

## Operation
- **Registers**
  - 0x0 RXDATA (read-only): bits [7:0] = RX FIFO head; the read pops the FIFO. Reading an empty FIFO returns 0 and does not pop.
  - 0x4 TXDATA (write-only): pushes `dat_i[7:0]` into the TX FIFO. A write to a full FIFO is dropped. Reads return 0.
  - 0x8 STATUS
    - Read-only bits: b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 busy (synced `csb` low and enabled).
    - Sticky bits: b5 rx_ovf, b6 tx_unf, b7 frame_end. Writing 1 to a sticky bit clears it; writing 0 has no effect.
  - 0xC CTRL (read/write): b0 enable, b1 rx_ie, b2 end_ie. Other bits read 0.
- **Interrupt:** `IRQ` = (rx_ie & ~rx_empty) | (end_ie & frame_end). It is registered and holds its level until the cause clears.
- **Pin sampling:** `sclk`, `csb` and `mosi` pass through `SYNC_STAGES` flops. Edges are detected from the last synced stage and the flop after it.
- **Engine states**
  - IDLE to SHIFT: on a synced `csb` falling edge while enable=1.
    - Load the TX shifter from the TX FIFO head and pop it.
    - If the TX FIFO is empty, load 0x00 and set tx_unf.
    - bitcnt=0; `miso` = shifter[7].
  - SHIFT, synced `sclk` rising edge: shift synced `mosi` into rx_shift LSB-first-in, so the byte is MSB first; bitcnt++.
  - SHIFT, bitcnt reaches 8:
    - Push rx_shift into the RX FIFO. If the RX FIFO is full, drop the byte and set rx_ovf.
    - bitcnt=0. Mark the next byte load as pending.
  - SHIFT, synced `sclk` falling edge:
    - If a load is pending: load the next TX byte using the same pop/underflow rule, and drive its bit 7.
    - Otherwise: shift the TX shifter left and drive the new bit 7.
  - SHIFT to IDLE: on a synced `csb` rising edge, or when enable is cleared.
    - A partial byte (bitcnt≠0) is discarded.
    - frame_end is set on the `csb` rising edge only.
- **Output enable:** `miso_oe` = enable & synced `csb` low. `miso` = 0 whenever `miso_oe`=0.
- **FIFO counts:** RX and TX FIFOs hold counts 0..`FIFO_DEPTH`. Pointers are `log2(FIFO_DEPTH)` bits and wrap modulo the depth.
- **Simultaneous push and pop:** both take effect and the count is unchanged.
  - On a full FIFO, a push in the same cycle as a pop succeeds.
  - On an empty FIFO, a pop in the same cycle as a push returns 0 and does not pop.
- **Sticky-bit priority:** a set event in the same cycle as a W1C write leaves the bit set.

## Timing
- **Reset values:** `ack_o`=0, `dat_o`=0, `IRQ`=0, `miso`=0, `miso_oe`=0, CTRL=0, FIFOs empty, sticky bits 0, engine IDLE.
- **Wishbone handshake**
  - `ack_o` asserts in the cycle after `cyc_i & stb_i`, for exactly one cycle.
  - `ack_o` is never asserted in two consecutive cycles, so the next ack needs a fresh strobe cycle.
  - Register side effects (pop, push, W1C) fire once, in the cycle `ack_o` is set.
  - `dat_o` is valid together with `ack_o`.
- **Pin latency:** from a pin edge to the engine acting on it is `SYNC_STAGES`+1 cycles. `miso` changes 1 cycle after the engine acts.
- **Clock requirement:** `clk_i` ≥ 8× the `sclk` frequency, with `csb` setup and hold ≥ one `sclk` half-period. Below this ratio, behaviour is undefined.
- **Reset mid-frame:** the engine returns to IDLE and the frame is ignored until the next `csb` falling edge.

## Test plan
- **Single-byte round trip:** set CTRL=0x1, write TXDATA 0xA5; controller sends 0x3C in one frame → controller receives 0xA5; RXDATA reads 0x3C; STATUS has frame_end=1 and rx_empty=0.
- **Multi-byte frame:** preload TX with 0x11, 0x22, 0x33; send 0xDE, 0xAD, 0xBE under a single `csb` low → MISO carries 0x11, 0x22, 0x33; RX holds DE, AD, BE in order.
- **Underflow and overflow, with `FIFO_DEPTH`=4 and an empty TX FIFO:** send 5 bytes → MISO returns 0x00 ×5; tx_unf=1; RX keeps the first 4 bytes; rx_ovf=1. Writing 0x60 to STATUS clears both bits.
- **Interrupts:** CTRL=0x3 → `IRQ` rises after the first received byte and stays high until RX is drained. With rx_ie=0 and end_ie=1, `IRQ` follows frame_end and drops after a W1C of 0x80.
- **Abort and disable**
  - Raise `csb` after 3 bits → no RX push; frame_end=1.
  - Clear enable mid-byte → `miso_oe`=0 within 1 cycle and the engine goes IDLE.
  - Assert `rst_i` mid-frame → all outputs return to their reset values.
- **Full-FIFO simultaneous events:** RX full, and a Wishbone RXDATA read acks in the same cycle as an SPI byte push → the push is accepted, rx_ovf stays 0, and rx_full remains 1.
